// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state type and the element-compare helper used by sort_engine.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } sort_state_t;

  // Compare operands are zero-extended to this width, so data words up to 32 bits are supported.
  localparam int unsigned CMP_W = 32;

  // True when b (the probe element) must be exchanged with a (the anchor element).
  // Equal values never report out of order, so duplicates are never swapped.
  function automatic logic out_of_order(input logic [CMP_W-1:0] a,
                                        input logic [CMP_W-1:0] b,
                                        input logic             desc);
    logic ooo;
    if (desc) ooo = (b > a);
    else      ooo = (b < a);
    return ooo;
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// sort_engine_if: host-side load/start/readback signal group for sort_engine.
// Optional member SwapCnt exists only when SORT_SWAPCNT_EN is defined.
interface sort_engine_if #(
  parameter int N = 8,
  parameter int L = 4
);
  logic         Rd;
  logic         WrInit;
  logic [L-1:0] RAddr;
  logic [N-1:0] DataIn;
  logic [L:0]   Len;
  logic         Desc;
  logic         start;
  logic [N-1:0] DataOut;
  logic         busy;
  logic         done;
`ifdef SORT_SWAPCNT_EN
  logic [2*L-1:0] SwapCnt;

  modport master (output Rd, WrInit, RAddr, DataIn, Len, Desc, start,
                  input  DataOut, busy, done, SwapCnt);
  modport slave  (input  Rd, WrInit, RAddr, DataIn, Len, Desc, start,
                  output DataOut, busy, done, SwapCnt);
`else
  modport master (output Rd, WrInit, RAddr, DataIn, Len, Desc, start,
                  input  DataOut, busy, done);
  modport slave  (input  Rd, WrInit, RAddr, DataIn, Len, Desc, start,
                  output DataOut, busy, done);
`endif
endinterface

// File: rtl/sort_mem.sv
// sort_mem: register-array RAM with a host write port, a registered host read port,
// two combinational sort read ports and a paired write port for exchanges.
// Contents are deliberately not reset.
module sort_mem #(
  parameter int N     = 8,
  parameter int L     = 4,
  parameter int DEPTH = 2**L
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         host_we,
  input  logic         host_re,
  input  logic [L-1:0] host_addr,
  input  logic [N-1:0] host_wdata,
  output logic [N-1:0] host_rdata,
  input  logic [L:0]   addr_i,
  input  logic [L:0]   addr_j,
  output logic [N-1:0] rdata_i,
  output logic [N-1:0] rdata_j,
  input  logic         swap_we,
  input  logic [N-1:0] wdata_i,
  input  logic [N-1:0] wdata_j
);

  logic [N-1:0] mem_r [DEPTH];
  logic [N-1:0] host_rd_s;
  logic [L:0]   host_addr_s;

  assign host_addr_s = {1'b0, host_addr};

  // Read muxes built as OR of one-hot matches; an address beyond DEPTH matches nothing and reads zero.
  always_comb begin
    host_rd_s = {N{1'b0}};
    rdata_i   = {N{1'b0}};
    rdata_j   = {N{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      host_rd_s = host_rd_s | ({N{host_addr_s == (L+1)'(k)}} & mem_r[k]);
      rdata_i   = rdata_i   | ({N{addr_i      == (L+1)'(k)}} & mem_r[k]);
      rdata_j   = rdata_j   | ({N{addr_j      == (L+1)'(k)}} & mem_r[k]);
    end
  end

  // Entry update: exchange pair while sorting, host load otherwise; out-of-range host writes match no entry.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (swap_we && (addr_i == (L+1)'(k)))
        mem_r[k] <= wdata_i;
      else if (swap_we && (addr_j == (L+1)'(k)))
        mem_r[k] <= wdata_j;
      else if (host_we && (host_addr_s == (L+1)'(k)))
        mem_r[k] <= host_wdata;
    end
  end

  // Registered host read data; holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst)
      host_rdata <= {N{1'b0}};
    else if (host_re)
      host_rdata <= host_rd_s;
  end

endmodule

// File: rtl/sort_engine.sv
// sort_engine: in-place exchange sort coprocessor over sort_mem.
// Anchor i walks 0..len-2; probe j walks i+1..len-1, one comparison per cycle.
// Optional: define SORT_SWAPCNT_EN to add the SwapCnt exchange counter.
module sort_engine
  import sort_pkg::*;
#(
  parameter int N     = 8,
  parameter int L     = 4,
  parameter int DEPTH = 2**L
) (
  input logic          clk,
  input logic          rst,
  sort_engine_if.slave bus
);

  sort_state_t  state_r;
  logic [L:0]   i_r;
  logic [L:0]   j_r;
  logic [L:0]   len_r;
  logic [N-1:0] ai_r;
  logic         desc_r;
  logic         busy_r;
  logic         done_r;
  logic [L:0]   len_eff_s;
  logic         host_we_s;
  logic         host_re_s;
  logic         swap_s;
  logic [N-1:0] rdata_i_s;
  logic [N-1:0] rdata_j_s;
`ifdef SORT_SWAPCNT_EN
  logic [2*L-1:0] swapcnt_r;
  assign bus.SwapCnt = swapcnt_r;
`endif

  // Requested length clamped to the RAM depth.
  assign len_eff_s = (bus.Len > (L+1)'(DEPTH)) ? (L+1)'(DEPTH) : bus.Len;
  // Host port is locked out for the whole sort.
  assign host_we_s = bus.WrInit & ~busy_r;
  assign host_re_s = bus.Rd & ~busy_r;
  // Exchange when the probe element belongs before the current anchor value.
  assign swap_s    = (state_r == CMP) && out_of_order(32'(ai_r), 32'(rdata_j_s), desc_r);

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

  sort_mem #(.N(N), .L(L), .DEPTH(DEPTH)) u_mem (
    .clk        (clk),
    .rst        (rst),
    .host_we    (host_we_s),
    .host_re    (host_re_s),
    .host_addr  (bus.RAddr),
    .host_wdata (bus.DataIn),
    .host_rdata (bus.DataOut),
    .addr_i     (i_r),
    .addr_j     (j_r),
    .rdata_i    (rdata_i_s),
    .rdata_j    (rdata_j_s),
    .swap_we    (swap_s),
    .wdata_i    (rdata_j_s),
    .wdata_j    (ai_r)
  );

  // Sort sequencer: start acceptance, anchor load, pairwise compare/exchange, completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      i_r       <= {(L+1){1'b0}};
      j_r       <= {(L+1){1'b0}};
      len_r     <= {(L+1){1'b0}};
      ai_r      <= {N{1'b0}};
      desc_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef SORT_SWAPCNT_EN
      swapcnt_r <= {(2*L){1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            len_r     <= len_eff_s;
            desc_r    <= bus.Desc;
            i_r       <= {(L+1){1'b0}};
`ifdef SORT_SWAPCNT_EN
            swapcnt_r <= {(2*L){1'b0}};
`endif
            if (len_eff_s < (L+1)'(2)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= LOAD;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end
        end
        LOAD: begin
          ai_r    <= rdata_i_s;
          j_r     <= i_r + (L+1)'(1);
          state_r <= CMP;
        end
        CMP: begin
          if (swap_s) begin
            ai_r      <= rdata_j_s;
`ifdef SORT_SWAPCNT_EN
            swapcnt_r <= swapcnt_r + (2*L)'(1);
`endif
          end
          if (j_r == len_r - (L+1)'(1)) begin
            if (i_r == len_r - (L+1)'(2)) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              i_r     <= i_r + (L+1)'(1);
              state_r <= LOAD;
            end
          end else begin
            j_r <= j_r + (L+1)'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed plus randomized checks of sort_engine against a sorted-queue reference.
module tb_sort_engine;

  localparam int N     = 8;
  localparam int L     = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [N-1:0] m [DEPTH];
  logic [N-1:0] base [8];

  sort_engine_if #(.N(N), .L(L)) bus ();

  sort_engine #(.N(N), .L(L), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int a, input logic [N-1:0] d);
    bus.WrInit = 1'b1;
    bus.RAddr  = a[L-1:0];
    bus.DataIn = d;
    tick();
    bus.WrInit = 1'b0;
    m[a] = d;
  endtask

  task automatic load_base();
    for (int k = 0; k < 8; k++) host_write(k, base[k]);
    for (int k = 8; k < DEPTH; k++) host_write(k, 8'($urandom));
  endtask

  task automatic load_random();
    for (int k = 0; k < DEPTH; k++) host_write(k, 8'($urandom));
  endtask

  task automatic readback(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      bus.Rd    = 1'b1;
      bus.RAddr = k[L-1:0];
      tick();
      bus.Rd    = 1'b0;
      check($sformatf("%s[%0d]", tag, k), 32'(bus.DataOut), 32'(m[k]));
    end
  endtask

`ifdef SORT_SWAPCNT_EN
  // Number of exchanges the anchor/probe rule performs on the current model contents.
  function automatic int ref_swaps(input int le, input bit desc);
    logic [N-1:0] a [DEPTH];
    logic [N-1:0] t;
    int c;
    c = 0;
    for (int k = 0; k < DEPTH; k++) a[k] = m[k];
    for (int x = 0; x < le - 1; x++)
      for (int y = x + 1; y < le; y++)
        if (desc ? (a[y] > a[x]) : (a[y] < a[x])) begin
          t = a[x]; a[x] = a[y]; a[y] = t; c++;
        end
    return c;
  endfunction
`endif

  task automatic run_sort(input string tag, input int len, input bit desc, input bit disturb);
    int le;
    int lat;
    int exp_lat;
    logic [N-1:0] held;
    logic [N-1:0] q[$];
`ifdef SORT_SWAPCNT_EN
    int exp_sw;
`endif
    le      = (len > DEPTH) ? DEPTH : len;
    exp_lat = (le < 2) ? 0 : (le - 1) + le * (le - 1) / 2;
`ifdef SORT_SWAPCNT_EN
    exp_sw  = ref_swaps(le, desc);
`endif
    for (int k = 0; k < le; k++) q.push_back(m[k]);
    if (desc) q.rsort();
    else      q.sort();
    for (int k = 0; k < le; k++) m[k] = q[k];
    bus.Len   = len[L:0];
    bus.Desc  = desc;
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.WrInit = 1'b0;
    lat = 0;
    check({tag, "_busy_start"}, 32'(bus.busy), (le >= 2) ? 32'd1 : 32'd0);
    if (le >= 2) check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
    held = bus.DataOut;
    while (bus.done !== 1'b1 && lat < 400) begin
      if (disturb) begin
        bus.Rd     = 1'($urandom);
        bus.WrInit = 1'($urandom);
        bus.start  = 1'($urandom);
        bus.RAddr  = 4'($urandom);
        bus.DataIn = 8'($urandom);
      end
      tick();
      lat++;
      if (disturb) check({tag, "_dout_hold"}, 32'(bus.DataOut), 32'(held));
    end
    bus.Rd     = 1'b0;
    bus.WrInit = 1'b0;
    bus.start  = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
`ifdef SORT_SWAPCNT_EN
    check({tag, "_swapcnt"}, 32'(bus.SwapCnt), 32'(exp_sw));
`endif
    readback(tag);
  endtask

  task automatic reset_mid_sort();
    logic [N-1:0] rb [DEPTH];
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    load_random();
    bus.Len   = 5'd16;
    bus.Desc  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("rstmid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.Rd    = 1'b1;
      bus.RAddr = k[L-1:0];
      tick();
      bus.Rd    = 1'b0;
      rb[k]     = bus.DataOut;
    end
    for (int k = 0; k < DEPTH; k++) begin
      qa.push_back(rb[k]);
      qb.push_back(m[k]);
    end
    qa.sort();
    qb.sort();
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("rstmid_perm[%0d]", k), 32'(qa[k]), 32'(qb[k]));
    run_sort("rstmid_resort", 16, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    base = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    rst        = 1'b1;
    bus.Rd     = 1'b0;
    bus.WrInit = 1'b0;
    bus.RAddr  = 4'd0;
    bus.DataIn = 8'd0;
    bus.Len    = 5'd0;
    bus.Desc   = 1'b0;
    bus.start  = 1'b0;
    tick();
    tick();
    check("rst_dout", 32'(bus.DataOut), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
`ifdef SORT_SWAPCNT_EN
    check("rst_swapcnt", 32'(bus.SwapCnt), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Ascending full 8-element case
    load_base();
    run_sort("asc8", 8, 1'b0, 1'b0);

    // Descending on the same data
    load_base();
    run_sort("desc8", 8, 1'b1, 1'b0);

    // Partial length: only addresses 0-2 change
    load_base();
    run_sort("len3", 3, 1'b0, 1'b0);

    // Degenerate lengths leave RAM untouched
    load_base();
    run_sort("len0", 0, 1'b0, 1'b0);
    run_sort("len1", 1, 1'b1, 1'b0);

    // Duplicates are never exchanged
    host_write(0, 8'd5);
    host_write(1, 8'd5);
    host_write(2, 8'd3);
    host_write(3, 8'd5);
    run_sort("dup4", 4, 1'b1, 1'b0);

    // Length beyond depth clamps to the full RAM
    load_random();
    run_sort("len20", 20, 1'b0, 1'b0);

    // Reset mid-sort, then a fresh sort
    reset_mid_sort();

    // Write issued together with start is included in the sort
    load_base();
    bus.WrInit = 1'b1;
    bus.RAddr  = 4'd2;
    bus.DataIn = 8'd200;
    m[2]       = 8'd200;
    run_sort("wr_start", 8, 1'b0, 1'b0);

    // Host activity while busy is ignored
    load_base();
    run_sort("lockout", 8, 1'b0, 1'b1);

    // Randomized lengths, orders and data
    for (int r = 0; r < 5; r++) begin
      load_random();
      run_sort($sformatf("rand%0d", r), int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised successor to the fixed 8-entry sorter: an in-place exchange sort over an internal register-array RAM.
- Adds runtime element count, runtime ascending/descending order and a busy indicator.
- Same host protocol as the current sorter: load via WrInit, kick with start, wait on done, read back via Rd.
- Sits behind a host controller or testbench as a self-contained sort coprocessor.

Parameters:
- N, 8, data word width in bits.
- L, 4, address width in bits.
- DEPTH, 2**L, number of RAM entries; must be between 2 and 2**L inclusive.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Rd  in  1  read request, honoured only when not busy.
- WrInit  in  1  initial-load write enable, honoured only when not busy.
- RAddr  in  L  host address for Rd/WrInit.
- DataIn  in  N  host write data.
- Len  in  L+1  number of elements to sort, sampled at start acceptance.
- Desc  in  1  order select (0 = ascending, 1 = descending), sampled at start acceptance.
- start  in  1  sort request, level-sampled.
- DataOut  out  N  registered read data.
- busy  out  1  sort in progress.
- done  out  1  sort complete, level.

Behaviour:
- Reset values: DataOut=0, busy=0, done=0, state=IDLE, counters=0.
- rst does not clear RAM contents.
- Host writes: WrInit=1 and not busy -> mem[RAddr]<=DataIn at the edge.
- Host reads: Rd=1 and not busy -> DataOut<=mem[RAddr] at the edge (1-cycle latency). DataOut holds otherwise.
- Out-of-range RAddr (>= DEPTH): writes are dropped; reads return 0.
- Effective length: len_eff = min(Len, DEPTH).
- FSM states: IDLE, LOAD, CMP, DONE.
- IDLE/DONE, start=1 at edge E0:
  - latch len_eff and Desc; clear done; i<=0.
  - if len_eff<2: go straight to DONE (done=1 after E0, RAM untouched).
  - otherwise go to LOAD with busy=1.
- LOAD: ai<=mem[i]; j<=i+1; go to CMP.
- CMP, one pair per cycle:
  - compare b=mem[j] with ai.
  - out-of-order condition: ascending b<ai, descending b>ai.
  - if out of order: mem[i]<=b, mem[j]<=ai, ai<=b (both writes at the same edge).
  - j==len_eff-1 and i==len_eff-2: go to DONE.
  - j==len_eff-1 otherwise: i<=i+1, go to LOAD.
  - else j<=j+1.
  - Equal values are never swapped.
- DONE: busy=0, done=1. Held until the next accepted start or rst.
- Latency: done rises at edge E0 + (len_eff-1) + len_eff*(len_eff-1)/2. For len_eff=8 this is E0+35.
- While busy:
  - Rd, WrInit and start are ignored.
  - DataOut holds its value.
- start with WrInit in the same cycle from IDLE/DONE: the write completes at E0 and is included in the sort.
- rst mid-sort: return to IDLE at that edge. RAM keeps its current partially sorted permutation of the original contents.
- Counter widths: i and j are L+1 bits so that DEPTH=2**L sorts without wrap.

Optional Feature:
- SORT_SWAPCNT_EN defined:
  - adds output SwapCnt, width 2*L.
  - cleared at start acceptance and on rst; increments once per swap.
  - holds its value in DONE.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sort_pkg holds:
  - state enum sort_state_t {IDLE, LOAD, CMP, DONE};
  - function out_of_order(a, b, desc).
- Sub-module sort_mem holds the register array:
  - host write port, registered host read port;
  - combinational sort-read ports for i and j;
  - dual write port for swaps.
- sort_engine keeps the FSM, counters and muxing.

Test Plan:
- Ascending: load 45,12,78,34,56,89,23,67; Len=8, Desc=0; pulse start -> done after 35 edges; readback 12,23,34,45,56,67,78,89.
- Descending: same data, Desc=1 -> readback 89,78,67,56,45,34,23,12; equal values are never swapped, e.g. 5,5,3,5 descending -> 5,5,5,3 with SwapCnt=1.
- Partial length: Len=3 on the same data -> 12,45,78 in addresses 0-2; addresses 3-7 unchanged; done after 5 edges.
- Degenerate lengths: Len=0 and Len=1 -> done=1 one edge after start, RAM unchanged. Len=20 with DEPTH=16 -> behaves as 16.
- Reset mid-sort: rst 10 cycles after start -> busy=0, done=0 next edge; readback is a permutation of the input; a fresh start then completes a correct sort.
- Lockout: Rd/WrInit/start toggled while busy -> RAM contents, DataOut and completion time are unaffected. With SORT_SWAPCNT_EN, the 8-value ascending case gives SwapCnt equal to the reference-model swap count.
